// File: rtl/mmio_store_bridge_pkg.sv
// Shared MMIO bridge definitions: default window map, window size and entry layout helper.
package mmio_store_bridge_pkg;

  localparam int          MMIO_ADDR_W     = 32;
  localparam int          MMIO_WIN_LOG2   = 13;
  localparam logic [31:0] MMIO_VIDEO_BASE = 32'h0000_8000;
  localparam logic [31:0] MMIO_UART_BASE  = 32'h0000_C000;
  // ch0 sits in the LSBs of the packed base vector
  localparam logic [63:0] MMIO_CH_BASE    = {MMIO_UART_BASE, MMIO_VIDEO_BASE};

  function automatic int entry_w(input int data_w, input int ch_w);
    return MMIO_ADDR_W + data_w + data_w / 8 + ch_w;
  endfunction

endpackage

// File: rtl/mmio_store_bridge_fifo.sv
// Flop-based first-word-fall-through FIFO; head word comes straight from the storage flops.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // pointers are PTR_W bits wide, so the increment wraps modulo DEPTH
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/mmio_store_bridge.sv
// MEM-stage store tap: decodes stores into address windows, buffers hits and drains them over valid/ready.
// Master port: an entry transfers on a cycle with m_valid & m_ready; m_* stay stable while m_valid & !m_ready.
module mmio_store_bridge
  import mmio_store_bridge_pkg::*;
#(
  parameter  int                  DATA_W   = 32,
  parameter  int                  DEPTH    = 8,
  parameter  int                  NUM_CH   = 2,
  parameter  int                  WIN_LOG2 = MMIO_WIN_LOG2,
  parameter  logic [NUM_CH*32-1:0] CH_BASE = MMIO_CH_BASE,
  parameter  bit                  REL_ADDR = 1'b0,
  parameter  bit                  STALL_EN = 1'b1,
  localparam int                  MASK_W   = DATA_W / 8,
  localparam int                  CH_W     = $clog2(NUM_CH) + 1,
  localparam int                  CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [MASK_W-1:0] st_mask,
  output logic              st_hit,
  output logic              stall,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_addr,
  output logic [DATA_W-1:0] m_data,
  output logic [MASK_W-1:0] m_mask,
  output logic [CH_W-1:0]   m_ch,
  output logic [CNT_W-1:0]  count,
  output logic              drop_err,
  input  logic              err_clr
);

  localparam int          ENT_W    = entry_w(DATA_W, CH_W);
  localparam logic [31:0] OFF_MASK = 32'((64'd1 << WIN_LOG2) - 64'd1);

  logic             win_hit;
  logic [CH_W-1:0]  hit_ch;
  logic             want, push, pop, drop;
  logic             full, empty;
  logic [31:0]      ent_addr;
  logic [ENT_W-1:0] fifo_din, fifo_dout;
  logic             drop_err_q, drop_err_d;

  // scan from the top so the lowest matching channel is written last and wins
  always_comb begin
    win_hit = 1'b0;
    hit_ch  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (st_addr[31:WIN_LOG2] == CH_BASE[i*32+WIN_LOG2 +: 32-WIN_LOG2]) begin
        win_hit = 1'b1;
        hit_ch  = CH_W'(i);
      end
    end
  end

  assign st_hit   = st_valid & win_hit;
  assign want     = st_hit & (|st_mask) & ~flush;
  assign push     = want & ~full;
  assign stall    = STALL_EN & want & full;
  assign drop     = ~STALL_EN & want & full;
  assign pop      = m_valid & m_ready & ~flush;
  assign ent_addr = REL_ADDR ? (st_addr & OFF_MASK) : st_addr;
  assign fifo_din = {ent_addr, st_data, st_mask, hit_ch};

  sync_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .din  (fifo_din),
    .dout (fifo_dout),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign m_valid = ~empty;
  assign {m_addr, m_data, m_mask, m_ch} = fifo_dout;

  // a drop in the same cycle as err_clr keeps the flag set
  always_comb begin
    drop_err_d = drop_err_q;
    if (err_clr) drop_err_d = 1'b0;
    if (drop)    drop_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_err_q <= 1'b0;
    else     drop_err_q <= drop_err_d;
  end

  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_mmio_store_bridge.sv
// Bench for mmio_store_bridge: a stalling full-address instance and a dropping relative-address instance
// share one stimulus stream and are checked every cycle against queue-based models.
module tb_mmio_store_bridge;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  ch;
  } ent_t;

  logic        clk, rst;
  logic        st_valid, flush, m_ready, err_clr;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_mask;

  logic        st_hit_o   [2];
  logic        stall_o    [2];
  logic        m_valid_o  [2];
  logic [31:0] m_addr_o   [2];
  logic [31:0] m_data_o   [2];
  logic [3:0]  m_mask_o   [2];
  logic [1:0]  m_ch_o     [2];
  logic [3:0]  count_o    [2];
  logic        drop_err_o [2];

  ent_t exp_q0[$];
  ent_t exp_q1[$];
  logic exp_derr [2];
  logic last_hit [2];
  logic last_stall [2];
  int   n_vec, n_err;

  mmio_store_bridge #(.REL_ADDR(1'b0), .STALL_EN(1'b1)) u_stall (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_mask(st_mask), .st_hit(st_hit_o[0]), .stall(stall_o[0]), .flush(flush),
    .m_valid(m_valid_o[0]), .m_ready(m_ready), .m_addr(m_addr_o[0]), .m_data(m_data_o[0]),
    .m_mask(m_mask_o[0]), .m_ch(m_ch_o[0]), .count(count_o[0]), .drop_err(drop_err_o[0]),
    .err_clr(err_clr)
  );

  mmio_store_bridge #(.REL_ADDR(1'b1), .STALL_EN(1'b0)) u_drop (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_mask(st_mask), .st_hit(st_hit_o[1]), .stall(stall_o[1]), .flush(flush),
    .m_valid(m_valid_o[1]), .m_ready(m_ready), .m_addr(m_addr_o[1]), .m_data(m_data_o[1]),
    .m_mask(m_mask_o[1]), .m_ch(m_ch_o[1]), .count(count_o[1]), .drop_err(drop_err_o[1]),
    .err_clr(err_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] win_base(input int i);
    return (i == 0) ? 32'h0000_8000 : 32'h0000_C000;
  endfunction

  function automatic bit in_win(input logic [31:0] a, input int i);
    return (a >= win_base(i)) && (a < win_base(i) + 32'd8192);
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic chk_state(input int k, input int sz, input ent_t head);
    chk("count", k, 64'(count_o[k]), 64'(sz));
    chk("m_valid", k, 64'(m_valid_o[k]), 64'(sz > 0));
    chk("drop_err", k, 64'(drop_err_o[k]), 64'(exp_derr[k]));
    if (sz > 0) begin
      chk("m_addr", k, 64'(m_addr_o[k]), 64'(head.addr));
      chk("m_data", k, 64'(m_data_o[k]), 64'(head.data));
      chk("m_mask", k, 64'(m_mask_o[k]), 64'(head.mask));
      chk("m_ch",   k, 64'(m_ch_o[k]),   64'(head.ch));
    end
  endtask

  task automatic idle(input logic rdy);
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_mask = '0;
    flush = 1'b0; err_clr = 1'b0; m_ready = rdy;
  endtask

  // driver + compare + model step for one clock
  task automatic cycle(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] mk, input logic rdy, input logic fl, input logic clr);
    bit   mhit, want, full0, full1;
    logic [1:0] mch;
    ent_t e0, e1, h0, h1;
    @(negedge clk);
    st_valid = v; st_addr = a; st_data = d; st_mask = mk;
    m_ready = rdy; flush = fl; err_clr = clr;
    #1;
    mhit  = v && (in_win(a, 0) || in_win(a, 1));
    mch   = in_win(a, 0) ? 2'd0 : 2'd1;
    want  = mhit && (mk != 4'h0) && !fl;
    full0 = (exp_q0.size() == 8);
    full1 = (exp_q1.size() == 8);
    h0 = (exp_q0.size() > 0) ? exp_q0[0] : '0;
    h1 = (exp_q1.size() > 0) ? exp_q1[0] : '0;
    chk_state(0, exp_q0.size(), h0);
    chk_state(1, exp_q1.size(), h1);
    chk("st_hit", 0, 64'(st_hit_o[0]), 64'(mhit));
    chk("st_hit", 1, 64'(st_hit_o[1]), 64'(mhit));
    chk("stall", 0, 64'(stall_o[0]), 64'(want && full0));
    chk("stall", 1, 64'(stall_o[1]), 64'd0);
    last_hit[0] = st_hit_o[0];  last_hit[1] = st_hit_o[1];
    last_stall[0] = stall_o[0]; last_stall[1] = stall_o[1];
    @(posedge clk);
    e0 = '{addr: a, data: d, mask: mk, ch: mch};
    e1 = '{addr: a - win_base(int'(mch)), data: d, mask: mk, ch: mch};
    if (fl) begin
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (exp_q0.size() > 0 && rdy) void'(exp_q0.pop_front());
      if (exp_q1.size() > 0 && rdy) void'(exp_q1.pop_front());
      if (want && !full0) exp_q0.push_back(e0);
      if (want && !full1) exp_q1.push_back(e1);
    end
    if (clr) exp_derr[0] = 1'b0;
    if (want && full1) exp_derr[1] = 1'b1;
    else if (clr)      exp_derr[1] = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rm;
    logic        rv;
    int          sel;
    n_vec = 0; n_err = 0;
    exp_derr[0] = 1'b0; exp_derr[1] = 1'b0;
    rst = 1'b1;
    idle(1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_count", k, 64'(count_o[k]), 64'd0);
      chk("rst_m_valid", k, 64'(m_valid_o[k]), 64'd0);
      chk("rst_drop_err", k, 64'(drop_err_o[k]), 64'd0);
      chk("rst_m_addr", k, 64'(m_addr_o[k]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // single store into window 0, drained immediately
    cycle(1, 32'h8004, 32'hDEAD_BEEF, 4'hF, 1, 0, 0);
    chk("t1_hit", 0, 64'(last_hit[0]), 64'd1);
    #2;
    chk("t1_m_valid", 0, 64'(m_valid_o[0]), 64'd1);
    chk("t1_m_addr", 0, 64'(m_addr_o[0]), 64'h8004);
    chk("t1_m_ch", 0, 64'(m_ch_o[0]), 64'd0);
    chk("t1_m_data", 0, 64'(m_data_o[0]), 64'hDEAD_BEEF);
    chk("t1_rel_addr", 1, 64'(m_addr_o[1]), 64'h0004);
    cycle(0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("t1_count", 0, 64'(count_o[0]), 64'd0);

    // window 1 with relative addressing, then a miss
    cycle(1, 32'hC010, 32'h1234_5678, 4'h3, 1, 0, 0);
    #2;
    chk("t2_rel_addr", 1, 64'(m_addr_o[1]), 64'h10);
    chk("t2_m_ch", 1, 64'(m_ch_o[1]), 64'd1);
    chk("t2_full_addr", 0, 64'(m_addr_o[0]), 64'hC010);
    cycle(1, 32'h4000, 32'h5555_AAAA, 4'hF, 1, 0, 0);
    chk("t2_miss_hit", 0, 64'(last_hit[0]), 64'd0);
    #2;
    chk("t2_count", 0, 64'(count_o[0]), 64'd0);
    chk("t2_count", 1, 64'(count_o[1]), 64'd0);

    // fill with no ready: 9th store stalls one instance and drops on the other
    for (int i = 0; i < 9; i++) cycle(1, 32'h8000 + 32'(4 * i), 32'h100 + 32'(i), 4'hF, 0, 0, 0);
    chk("t3_stall9", 0, 64'(last_stall[0]), 64'd1);
    chk("t4_nostall", 1, 64'(last_stall[1]), 64'd0);
    #2;
    chk("t3_count", 0, 64'(count_o[0]), 64'd8);
    chk("t4_count", 1, 64'(count_o[1]), 64'd8);
    chk("t4_drop_err", 1, 64'(drop_err_o[1]), 64'd1);
    cycle(1, 32'h8020, 32'h108, 4'hF, 0, 0, 1);
    #2;
    chk("t4_clr_vs_drop", 1, 64'(drop_err_o[1]), 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("t4_clr", 1, 64'(drop_err_o[1]), 64'd0);
    cycle(1, 32'h8020, 32'h108, 4'hF, 1, 0, 0);
    chk("t3_no_bypass", 0, 64'(last_stall[0]), 64'd1);
    #2;
    chk("t3_count7", 0, 64'(count_o[0]), 64'd7);
    cycle(1, 32'h8020, 32'h108, 4'hF, 1, 0, 0);
    chk("t3_retry_ok", 0, 64'(last_stall[0]), 64'd0);
    #2;
    chk("t3_head", 0, 64'(m_data_o[0]), 64'h102);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 0);

    // flush together with a store at count 5
    for (int i = 0; i < 5; i++) cycle(1, 32'hC000 + 32'(4 * i), 32'h200 + 32'(i), 4'hF, 0, 0, 0);
    #2;
    chk("t5_count5", 0, 64'(count_o[0]), 64'd5);
    cycle(1, 32'hC100, 32'h2FF, 4'hF, 0, 1, 0);
    chk("t5_stall", 0, 64'(last_stall[0]), 64'd0);
    #2;
    chk("t5_count", 0, 64'(count_o[0]), 64'd0);
    chk("t5_m_valid", 1, 64'(m_valid_o[1]), 64'd0);

    // async reset mid-drain at count 3
    for (int i = 0; i < 4; i++) cycle(1, 32'h9000 + 32'(4 * i), 32'h300 + 32'(i), 4'hF, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("t6_count3", 0, 64'(count_o[0]), 64'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_count", 0, 64'(count_o[0]), 64'd0);
    chk("t6_rst_m_valid", 0, 64'(m_valid_o[0]), 64'd0);
    chk("t6_rst_m_addr", 0, 64'(m_addr_o[0]), 64'd0);
    chk("t6_rst_m_data", 0, 64'(m_data_o[0]), 64'd0);
    chk("t6_rst_m_mask", 0, 64'(m_mask_o[0]), 64'd0);
    chk("t6_rst_m_ch", 0, 64'(m_ch_o[0]), 64'd0);
    exp_q0.delete(); exp_q1.delete();
    exp_derr[0] = 1'b0; exp_derr[1] = 1'b0;
    idle(1'b0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 32'h8010, 32'hFFFF_0000, 4'h0, 0, 0, 0);
    chk("t6_mask0_hit", 0, 64'(last_hit[0]), 64'd1);
    chk("t6_mask0_stall", 0, 64'(last_stall[0]), 64'd0);
    #2;
    chk("t6_mask0_count", 0, 64'(count_o[0]), 64'd0);

    // randomized traffic; a stalled store is retried as the core would
    rv = 1'b0; ra = '0; rd = '0; rm = '0;
    for (int n = 0; n < 800; n++) begin
      if (!last_stall[0]) begin
        rv  = ($urandom_range(0, 9) < 8);
        sel = $urandom_range(0, 9);
        if (sel < 4)       ra = 32'h8000 + 32'($urandom_range(0, 32'h1FFF));
        else if (sel < 7)  ra = 32'hC000 + 32'($urandom_range(0, 32'h1FFF));
        else if (sel == 7) ra = 32'h4000 + 32'($urandom_range(0, 32'h1FFF));
        else if (sel == 8) ra = 32'hA000 + 32'($urandom_range(0, 32'h1FFF));
        else               ra = $urandom;
        rd = $urandom;
        rm = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      cycle(rv, ra, rd, rm,
            ((n / 50) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 5));
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
